vga_scan_ctrl: RTL
==================

// Module: vga_scan_ctrl
// PURPOSE
//  Parametrised VGA scan controller; next generation of the display timing block.
//  Generates HSYNC/VSYNC, framebuffer/sprite read requests (scaled coordinates) and colour output.
//  Colour output is aligned to a pixel source of configurable latency; mono or RGB332 colour mode.
//  Emits frame_start and vblank_start strobes; vblank_start drives the game-logic move tick.
//  Sits between the DCM clock domain top level and the pixel source (game/sprite logic or RAM).
// PARAMETERS
//  CLK_DIV      2    clk cycles per pixel (>=1); a pixel tick fires every CLK_DIV clk
//  H_ACTIVE     640  visible pixels per line
//  H_FRONT      16   horizontal front porch, pixels
//  H_SYNC       96   hsync width, pixels
//  H_BACK       48   horizontal back porch, pixels
//  V_ACTIVE     400  visible lines
//  V_FRONT      12   vertical front porch, lines
//  V_SYNC       2    vsync width, lines
//  V_BACK       35   vertical back porch, lines
//  H_POL        1    hsync active level (1 = active-high)
//  V_POL        1    vsync active level
//  SCALE_LOG2   1    read coordinate = counter >> SCALE_LOG2 (1 -> 320x200 logical)
//  PIX_LAT      1    clk cycles from rd_en/rd_x/rd_y to valid pix_data (0..7)
//  XW / YW      9/8  rd_x / rd_y widths
// PORTS
//  clk          in   1   system clock (pixel clock x CLK_DIV)
//  rst          in   1   synchronous, active-high reset
//  pix_mode     in   1   0 = mono (pix_data[0] -> white), 1 = RGB332 direct; sample only in blanking
//  pix_data     in   8   pixel from source, valid PIX_LAT clk after request
//  rd_en        out  1   read request, high during visible area
//  rd_x         out  XW  scaled column, 0 outside visible area
//  rd_y         out  YW  scaled row, 0 outside visible area
//  HSYNC        out  1   horizontal sync
//  VSYNC        out  1   vertical sync
//  VGAR         out  3   red
//  VGAG         out  3   green
//  VGAB         out  2   blue
//  frame_start  out  1   one-clk pulse on the tick entering h=0,v=0
//  vblank_start out  1   one-clk pulse on the tick entering h=0,v=V_ACTIVE
// BEHAVIOUR
//  Reset: div_cnt=0, h=0, v=0, rd_en=0, rd_x=rd_y=0, colour=0, strobes=0, HSYNC=!H_POL, VSYNC=!V_POL.
//  Tick: div_cnt counts 0..CLK_DIV-1, tick when div_cnt==CLK_DIV-1 (CLK_DIV=1 -> every clk).
//  On tick: h wraps at H_TOTAL-1 to 0; then v increments, wrapping at V_TOTAL-1 to 0.
//  H_TOTAL/V_TOTAL = sum of the four h/v params; counter widths = $clog2(TOTAL).
//  Stage 0 (registered from counters, every clk):
//    rd_en = h<H_ACTIVE && v<V_ACTIVE; rd_x/rd_y = h/v >> SCALE_LOG2 when rd_en, else 0.
//    HSYNC/VSYNC active for h in [H_ACTIVE+H_FRONT, +H_SYNC) / v in [V_ACTIVE+V_FRONT, +V_SYNC).
//  Sync, visible flag and mode are delayed PIX_LAT clk, so they align with pix_data.
//  Colour register: if delayed visible=0 -> 0; mono: pix_data[0] ? {7,7,3} : 0;
//    RGB332: R=pix_data[7:5], G=[4:2], B=[1:0].
//  Total latency counter -> pins = 1+PIX_LAT clk for sync and colour alike; strobes = 1 clk.
//  pix_mode change takes effect only when v>=V_ACTIVE; no mid-frame mode tearing.
//  Reset mid-frame: everything returns to reset state next clk; delay line flushed to
//    blank/inactive sync; first frame_start follows the first tick after release.
//  Elaboration: $error if CLK_DIV<1, PIX_LAT>7, or H_ACTIVE>>SCALE_LOG2 exceeds 2**XW.
// STRUCTURE
//  Package vga_pkg: timing presets (640x400@70, 640x480@60) as localparam sets,
//    RGB332 field positions, mono foreground colour constant.
//  Sub-module vga_delay_line #(W, DEPTH): sync-reset shift register; DEPTH=0 is a wire.
//  Counters, tick divider, stage-0 decode and colour mux stay in vga_scan_ctrl.
// TESTING
//  Reset hold 5 clk -> all outputs at reset values; HSYNC=VSYNC=0 with H_POL=V_POL=1.
//  Defaults: HSYNC period = 1600 clk, high for 192 clk; VSYNC period = 449 lines, high for 2 lines.
//  Count strobes over 3 frames -> one frame_start and one vblank_start per 718400 clk.
//  PIX_LAT=3, source returns rd_x[0] as mono -> VGAR toggles 7/0 every 4 clk, first visible at col 0.
//  SCALE_LOG2=1: h=639,v=399 -> rd_x=319, rd_y=199; h=640 -> rd_en=0, rd_x=0.
//  rst pulsed at h=300,v=200 -> next clk counters 0, colour 0; frame_start after first tick.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: timing presets, RGB332 pixel layout and mono foreground colour for the VGA scan controller
package vga_pkg;
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;
  typedef struct packed {
    int unsigned active;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } vga_axis_t;
  localparam rgb332_t   MONO_FG = '{r: 3'd7, g: 3'd7, b: 2'd3};
  localparam vga_axis_t H_640   = '{640, 16, 96, 48};
  localparam vga_axis_t V_400   = '{400, 12, 2, 35};
  localparam vga_axis_t V_480   = '{480, 10, 2, 33};
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: sync-reset shift register of DEPTH stages; DEPTH=0 passes the input straight through
module vga_delay_line #(
  parameter int             W     = 1,
  parameter int             DEPTH = 1,
  parameter logic [W-1:0]   RST   = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = clk ^ rst;
    assign o_q      = i_d;
  end else begin : g_sr
    logic [W-1:0] r_sr [DEPTH];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST;
      end else begin
        r_sr[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
    end
    assign o_q = r_sr[DEPTH-1];
  end
endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA timing, scaled read requests and colour output aligned to a fixed-latency pixel source
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = H_640.active,
  parameter int H_FRONT    = H_640.front,
  parameter int H_SYNC     = H_640.sync,
  parameter int H_BACK     = H_640.back,
  parameter int V_ACTIVE   = V_400.active,
  parameter int V_FRONT    = V_400.front,
  parameter int V_SYNC     = V_400.sync,
  parameter int V_BACK     = V_400.back,
  parameter bit H_POL      = 1'b1,
  parameter bit V_POL      = 1'b1,
  parameter int SCALE_LOG2 = 1,
  parameter int PIX_LAT    = 1,
  parameter int XW         = 9,
  parameter int YW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_mode,
  input  logic [7:0]    pix_data,
  output logic          rd_en,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic [2:0]    VGAR,
  output logic [2:0]    VGAG,
  output logic [1:0]    VGAB,
  output logic          frame_start,
  output logic          vblank_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  if (CLK_DIV < 1) begin : g_err_div
    $error("vga_scan_ctrl: CLK_DIV must be at least 1");
  end
  if (PIX_LAT < 0 || PIX_LAT > 7) begin : g_err_lat
    $error("vga_scan_ctrl: PIX_LAT must be in 0..7");
  end
  if ((H_ACTIVE >> SCALE_LOG2) > (1 << XW)) begin : g_err_xw
    $error("vga_scan_ctrl: scaled H_ACTIVE does not fit in XW bits");
  end
  logic [DW-1:0] r_div;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          r_hs, r_vs, r_mode;
  logic          w_tick, w_h_wrap, w_vis;
  logic [3:0]    w_dly;
  rgb332_t       w_pix;
  assign w_tick   = r_div == D_LAST;
  assign w_h_wrap = r_h == H_LAST;
  assign w_vis    = r_h < H_VIS && r_v < V_VIS;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_h <= w_h_wrap ? '0 : r_h + 1'b1;
        if (w_h_wrap) r_v <= r_v == V_LAST ? '0 : r_v + 1'b1;
      end
    end
  end
  // Mode is only picked up in vertical blanking so a frame never mixes mono and RGB
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en        <= 1'b0;
      rd_x         <= '0;
      rd_y         <= '0;
      r_hs         <= !H_POL;
      r_vs         <= !V_POL;
      r_mode       <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      rd_en        <= w_vis;
      rd_x         <= w_vis ? XW'(r_h >> SCALE_LOG2) : '0;
      rd_y         <= w_vis ? YW'(r_v >> SCALE_LOG2) : '0;
      r_hs         <= (r_h >= H_SS && r_h < H_SE) ? H_POL : !H_POL;
      r_vs         <= (r_v >= V_SS && r_v < V_SE) ? V_POL : !V_POL;
      r_mode       <= r_v >= V_VIS ? pix_mode : r_mode;
      frame_start  <= w_tick && r_h == '0 && r_v == '0;
      vblank_start <= w_tick && r_h == '0 && r_v == V_VIS;
    end
  end
  vga_delay_line #(
    .W    (4),
    .DEPTH(PIX_LAT),
    .RST  ({!H_POL, !V_POL, 2'b00})
  ) u_dly (
    .clk(clk),
    .rst(rst),
    .i_d({r_hs, r_vs, rd_en, r_mode}),
    .o_q(w_dly)
  );
  assign HSYNC = w_dly[3];
  assign VSYNC = w_dly[2];
  // pix_data arrives already registered by the source, so the mux sits directly on it to keep 1+PIX_LAT
  always_comb w_pix = !w_dly[1] ? '0 : w_dly[0] ? rgb332_t'(pix_data) : pix_data[0] ? MONO_FG : '0;
  assign VGAR = w_pix.r;
  assign VGAG = w_pix.g;
  assign VGAB = w_pix.b;
endmodule
